// File: rtl/tx_pkg.sv
// tx_pkg: shared constants and width helpers for the QPSK transmitter front end.
package tx_pkg;
    localparam int PRBS_TAP_OUT = 8;
    localparam int PRBS_TAP_FB  = 4;

    localparam logic signed [7:0] SYM_POS  = 8'sh40;
    localparam logic signed [7:0] SYM_NEG  = -8'sh40;
    localparam logic signed [7:0] SYM_ZERO = 8'sh00;

    localparam int NTAP_DEF = 24;
    localparam logic signed [7:0] H_TX_DEF [NTAP_DEF] = '{
        8'sd0, 8'sd0, 8'sd1, 8'sd1, 8'sd0, -8'sd4, -8'sd8, -8'sd8, 8'sd0, 8'sd17, 8'sd38, 8'sd57,
        8'sd64, 8'sd57, 8'sd38, 8'sd17, 8'sd0, -8'sd8, -8'sd8, -8'sd4, 8'sd0, 8'sd1, 8'sd1, 8'sd0
    };

    function automatic int prod_width(int nbt_coef, int nbt_dat);
        return nbt_coef + nbt_dat;
    endfunction

    function automatic int acc_width(int nbt_coef, int nbt_dat, int nbaud);
        return nbt_coef + nbt_dat + $clog2(nbaud);
    endfunction

    function automatic int align_shift(int nbf_coef, int nbt_dat, int nbf_out);
        return nbf_coef + nbt_dat - 2 - nbf_out;
    endfunction

    // bit 0 maps to +1, bit 1 to -1, in S(nbt_dat, nbt_dat-2)
    function automatic int sym_word(logic b, int nbt_dat);
        return b ? -(1 <<< (nbt_dat - 2)) : (1 <<< (nbt_dat - 2));
    endfunction

    function automatic int coef_tx(int n);
        return (n < NTAP_DEF) ? int'(H_TX_DEF[n]) : 0;
    endfunction
endpackage

// File: rtl/tx_prbs9.sv
// tx_prbs9: PRBS9 (x^9+x^5+1) generator, advancing one step per enabled edge.
module tx_prbs9
    import tx_pkg::*;
#(
    parameter logic [8:0] SEED = 9'h1AA
) (
    input  logic clk,
    input  logic i_reset,
    input  logic en,
    output logic bit_out
);
    logic [8:0] state;

    always_ff @(posedge clk or negedge i_reset)
        if (!i_reset) state <= SEED;
        else if (en)  state <= {state[7:0], state[PRBS_TAP_OUT] ^ state[PRBS_TAP_FB]};

    assign bit_out = state[PRBS_TAP_OUT];
endmodule

// File: rtl/tmp_top_tx.sv
// tmp_top_tx: free-running QPSK transmitter, PRBS9 -> +/-1 map -> polyphase RC FIR per branch.
// Define TX_OUT_SAT_EN to saturate the aligned output instead of wrapping.
module tmp_top_tx
    import tx_pkg::*;
#(
    parameter logic [8:0] SEED_I = 9'h1AA,
    parameter logic [8:0] SEED_Q = 9'h1FE,
    parameter int NBT_OUT     = 8,
    parameter int NBF_OUT     = 6,
    parameter int NBT_COEF_TX = 8,
    parameter int NBF_COEF_TX = 6,
    parameter int NBTOT_DAT   = 8,
    parameter int NBAUD       = 6,
    parameter int OVERSAMP    = 4
) (
    input  logic                      clk,
    input  logic                      i_reset,
    output logic signed [NBT_OUT-1:0] out_from_tx_filtI_to_noiseI,
    output logic signed [NBT_OUT-1:0] out_from_tx_filtQ_to_noiseQ
);
    localparam int PW = prod_width(NBT_COEF_TX, NBTOT_DAT);
    localparam int AW = acc_width(NBT_COEF_TX, NBTOT_DAT, NBAUD);
    localparam int SH = align_shift(NBF_COEF_TX, NBTOT_DAT, NBF_OUT);
    localparam int NT = NBAUD * OVERSAMP;
    localparam int CW = $clog2(OVERSAMP);
    localparam int IW = $clog2(NT);
    localparam logic signed [NBTOT_DAT-1:0] S_P = NBTOT_DAT'(sym_word(1'b0, NBTOT_DAT));
    localparam logic signed [NBTOT_DAT-1:0] S_N = NBTOT_DAT'(sym_word(1'b1, NBTOT_DAT));
    localparam logic signed [AW-1:0] OMAX = AW'((1 <<< (NBT_OUT - 1)) - 1);
    localparam logic signed [AW-1:0] OMIN = ~OMAX;

    logic [CW-1:0]                    cnt;
    logic [1:0]                       bits;
    logic [1:0][NBT_OUT-1:0]          y_all;
    logic signed [NBT_COEF_TX-1:0]    h [NT];

    always_ff @(posedge clk or negedge i_reset)
        if (!i_reset) cnt <= '0;
        else          cnt <= (cnt == CW'(OVERSAMP - 1)) ? '0 : cnt + 1'b1;

    tx_prbs9 #(.SEED(SEED_I)) u_prbs_i (.clk(clk), .i_reset(i_reset), .en(cnt == '0), .bit_out(bits[0]));
    tx_prbs9 #(.SEED(SEED_Q)) u_prbs_q (.clk(clk), .i_reset(i_reset), .en(cnt == '0), .bit_out(bits[1]));

    genvar n, b;
    for (n = 0; n < NT; n++) begin : g_h
        assign h[n] = NBT_COEF_TX'(coef_tx(n));
    end

    for (b = 0; b < 2; b++) begin : g_br
        logic signed [NBTOT_DAT-1:0] sreg [NBAUD];
        logic signed [PW-1:0]        p;
        logic signed [AW-1:0]        acc;
        logic signed [AW-1:0]        sh;
        logic signed [NBT_OUT-1:0]   y;
        logic signed [NBT_OUT-1:0]   q;

        always_ff @(posedge clk or negedge i_reset)
            if (!i_reset) begin
                for (int k = 0; k < NBAUD; k++) sreg[k] <= '0;
                q <= '0;
            end else begin
                if (cnt == '0) begin
                    sreg[0] <= bits[b] ? S_N : S_P;
                    for (int k = 1; k < NBAUD; k++) sreg[k] <= sreg[k-1];
                end
                q <= y;
            end

        // polyphase: phase cnt of the filter picks taps cnt, cnt+OVERSAMP, ...
        always_comb begin
            p   = '0;
            acc = '0;
            for (int k = 0; k < NBAUD; k++) begin
                p   = sreg[k] * h[IW'(k * OVERSAMP) + IW'(cnt)];
                acc = acc + AW'(p);
            end
            sh = acc >>> SH;
`ifdef TX_OUT_SAT_EN
            y = (sh > OMAX) ? NBT_OUT'(OMAX) : (sh < OMIN) ? NBT_OUT'(OMIN) : NBT_OUT'(sh);
`else
            y = NBT_OUT'(sh);
`endif
        end

        assign y_all[b] = q;
    end

    assign out_from_tx_filtI_to_noiseI = y_all[0];
    assign out_from_tx_filtQ_to_noiseQ = y_all[1];
endmodule

// File: tb/tb_tmp_top_tx.sv
// tb_tmp_top_tx: randomized-length runs and async resets checked against a symbol-level model.
module tb_tmp_top_tx;
    logic clk = 1'b0;
    logic i_reset = 1'b0;
    logic signed [7:0] oi, oq;
    int errors = 0;
    int checks = 0;
    int h [24] = '{0, 0, 1, 1, 0, -4, -8, -8, 0, 17, 38, 57,
                   64, 57, 38, 17, 0, -8, -8, -4, 0, 1, 1, 0};
    int e [2][4096];

    tmp_top_tx dut (
        .clk(clk),
        .i_reset(i_reset),
        .out_from_tx_filtI_to_noiseI(oi),
        .out_from_tx_filtQ_to_noiseQ(oq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // emitted bits obey e[n+9] = e[n] ^ e[n+4], first nine are the seed MSB first
    task automatic build_bits(input int br, input logic [8:0] seed);
        for (int i = 0; i < 9; i++) e[br][i] = int'(seed[8-i]);
        for (int i = 9; i < 4096; i++) e[br][i] = e[br][i-9] ^ e[br][i-5];
    endtask

    // output on edge t (t=1 first after release); symbols +/-64 times h, >>6, is just +/-h
    function automatic int ref_out(input int br, input int t);
        int ph, ns, m, s;
        ph = (t - 1) % 4;
        ns = (t + 2) / 4;
        s = 0;
        for (int k = 0; k < 6; k++) begin
            m = ns - 1 - k;
            if (m >= 0) s += (e[br][m] != 0) ? -h[k*4+ph] : h[k*4+ph];
        end
        return s;
    endfunction

    task automatic run(input int n);
        int vi, vq;
        for (int t = 1; t <= n; t++) begin
            @(posedge clk);
            #1;
            vi = int'(oi);
            vq = int'(oq);
            if (t <= 4) chk("first_i", vi, (t <= 2) ? 0 : -1);
            chk("out_i", vi, ref_out(0, t));
            chk("out_q", vq, ref_out(1, t));
            chk("range", int'(vi >= -94 && vi <= 94 && vq >= -94 && vq <= 94), 1);
        end
    endtask

    initial begin
        build_bits(0, 9'h1AA);
        build_bits(1, 9'h1FE);
        #50;
        chk("rst_i", int'(oi), 0);
        chk("rst_q", int'(oq), 0);
        #50;
        i_reset = 1'b1;
        run($urandom_range(2050, 2200));
        for (int r = 0; r < 3; r++) begin
            #($urandom_range(1, 3));
            i_reset = 1'b0;
            #1;
            chk("async_rst_i", int'(oi), 0);
            chk("async_rst_q", int'(oq), 0);
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #2;
            i_reset = 1'b1;
            run($urandom_range(40, 600));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
